// File: rtl/hemaia_clk_div_seq_pkg.sv
// Shared types and helpers for the HeMAiA clock-divider reconfiguration sequencer.
package hemaia_clk_div_seq_pkg;

  localparam int unsigned ReqChanW = 8;
  localparam int unsigned ReqDivW  = 16;

  typedef enum logic [2:0] {
    IDLE,
    GATE,
    LOAD,
    SETTLE,
    RESP
  } clk_div_seq_state_e;

  // Sized for the widest supported configuration; the top uses the low bits.
  typedef struct packed {
    logic [ReqChanW-1:0] chan;
    logic [ReqDivW-1:0]  divisor;
  } clk_div_req_t;

  function automatic int unsigned seq_timer_width(input int unsigned gate_cycles,
                                                  input int unsigned settle_cycles);
    int unsigned longest;
    longest = (gate_cycles > settle_cycles) ? gate_cycles : settle_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/hemaia_clk_div_seq_timer.sv
// Loadable down-counter; done_o pulses (registered) once the loaded count has elapsed.
module hemaia_clk_div_seq_timer #(
  parameter int unsigned Width = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [Width-1:0] load_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q;
  logic             done_q;

  // Loading N raises done_o N cycles after the start edge, so the owner
  // leaves its state after N+1 cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (start_i) begin
      cnt_q  <= load_i;
      done_q <= (load_i == '0);
    end else if (cnt_q != '0) begin
      cnt_q  <= cnt_q - Width'(1);
      done_q <= (cnt_q == Width'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/hemaia_clk_div_sequencer.sv
// Sequences glitch-free divisor changes: gate, load, settle, ungate, respond.
module hemaia_clk_div_sequencer
  import hemaia_clk_div_seq_pkg::*;
#(
  parameter int unsigned NumChannels      = 4,
  parameter int unsigned MaxDivisionWidth = 4,
  parameter int unsigned DefaultDivision  = 1,
  parameter int unsigned GateCycles       = 2,
  parameter int unsigned SettleCycles     = 32,
  parameter int unsigned ChanW            = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   req_valid_i,
  output logic                                   req_ready_o,
  input  logic [ChanW-1:0]                       req_chan_i,
  input  logic [MaxDivisionWidth-1:0]            req_divisor_i,
  output logic                                   rsp_valid_o,
  input  logic                                   rsp_ready_i,
  output logic                                   rsp_error_o,
  output logic [NumChannels*MaxDivisionWidth-1:0] divisor_o,
  output logic [NumChannels-1:0]                 divisor_valid_o,
  output logic [NumChannels-1:0]                 clk_en_o,
  output logic                                   busy_o
);

  localparam int unsigned TimerW = seq_timer_width(GateCycles, SettleCycles);
  localparam logic [TimerW-1:0] GateLoad   = TimerW'(GateCycles - 1);
  localparam logic [TimerW-1:0] SettleLoad = TimerW'(SettleCycles - 1);
  localparam logic [ChanW:0]    NumChan    = (ChanW + 1)'(NumChannels);
  localparam logic [MaxDivisionWidth-1:0] DefDiv = MaxDivisionWidth'(DefaultDivision);

  clk_div_seq_state_e state_q;
  clk_div_req_t       req_q;

  logic [NumChannels-1:0][MaxDivisionWidth-1:0] divisor_q;
  logic [NumChannels-1:0]                       divisor_valid_q;
  logic [NumChannels-1:0]                       clk_en_q;
  logic                                         rsp_valid_q;
  logic                                         rsp_error_q;

  logic                        req_err;
  logic                        req_noop;
  logic [MaxDivisionWidth-1:0] cur_div;
  logic [ChanW-1:0]            sel_chan;
  logic                        timer_start;
  logic [TimerW-1:0]           timer_load;
  logic                        timer_done;
  logic                        unused_req_bits;

  assign sel_chan        = req_q.chan[ChanW-1:0];
  assign unused_req_bits = ^{req_q.chan[ReqChanW-1:ChanW], req_q.divisor[ReqDivW-1:MaxDivisionWidth]};

  // Channel lookup by loop so an out-of-range index never reads past the array.
  always_comb begin
    cur_div = '0;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      if (ChanW'(c) == req_chan_i) cur_div = divisor_q[c];
    end
    req_err  = ({1'b0, req_chan_i} >= NumChan) || (req_divisor_i == '0);
    req_noop = !req_err && (req_divisor_i == cur_div);
  end

  // The timer restarts on every state change, mirroring the FSM transitions below.
  always_comb begin
    timer_start = 1'b0;
    timer_load  = '0;
    unique case (state_q)
      IDLE: begin
        timer_start = req_valid_i;
        timer_load  = (req_err || req_noop) ? '0 : GateLoad;
      end
      GATE:    timer_start = timer_done;
      LOAD: begin
        timer_start = 1'b1;
        timer_load  = SettleLoad;
      end
      SETTLE:  timer_start = timer_done;
      RESP:    timer_start = rsp_ready_i;
      default: timer_start = 1'b0;
    endcase
  end

  hemaia_clk_div_seq_timer #(
    .Width (TimerW)
  ) i_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (timer_start),
    .load_i  (timer_load),
    .done_o  (timer_done)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      req_q           <= '0;
      divisor_q       <= {NumChannels{DefDiv}};
      divisor_valid_q <= '0;
      clk_en_q        <= '1;
      rsp_valid_q     <= 1'b0;
      rsp_error_q     <= 1'b0;
    end else begin
      divisor_valid_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            req_q <= '{chan: ReqChanW'(req_chan_i), divisor: ReqDivW'(req_divisor_i)};
            if (req_err || req_noop) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= req_err;
            end else begin
              state_q <= GATE;
              for (int unsigned c = 0; c < NumChannels; c++) begin
                if (ChanW'(c) == req_chan_i) clk_en_q[c] <= 1'b0;
              end
            end
          end
        end
        GATE: begin
          if (timer_done) begin
            state_q <= LOAD;
            for (int unsigned c = 0; c < NumChannels; c++) begin
              if (ChanW'(c) == sel_chan) begin
                divisor_q[c]       <= req_q.divisor[MaxDivisionWidth-1:0];
                divisor_valid_q[c] <= 1'b1;
              end
            end
          end
        end
        LOAD: state_q <= SETTLE;
        SETTLE: begin
          if (timer_done) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b0;
            for (int unsigned c = 0; c < NumChannels; c++) begin
              if (ChanW'(c) == sel_chan) clk_en_q[c] <= 1'b1;
            end
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o     = (state_q == IDLE);
  assign busy_o          = (state_q != IDLE);
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_error_o     = rsp_error_q;
  assign divisor_o       = divisor_q;
  assign divisor_valid_o = divisor_valid_q;
  assign clk_en_o        = clk_en_q;

endmodule

// File: tb/tb_hemaia_clk_div_sequencer.sv
// Directed bench for hemaia_clk_div_sequencer with hand-computed expectations.
module tb_hemaia_clk_div_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_chan_i;
  logic [3:0]  req_divisor_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_error_o;
  logic [15:0] divisor_o;
  logic [3:0]  divisor_valid_o;
  logic [3:0]  clk_en_o;
  logic        busy_o;

  int nchk = 0;
  int nerr = 0;
  int strobe_cnt [4] = '{0, 0, 0, 0};

  always #5 clk_i = ~clk_i;

  hemaia_clk_div_sequencer #(
    .NumChannels      (4),
    .MaxDivisionWidth (4),
    .DefaultDivision  (1),
    .GateCycles       (2),
    .SettleCycles     (32),
    .ChanW            (3)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_chan_i      (req_chan_i),
    .req_divisor_i   (req_divisor_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_error_o     (rsp_error_o),
    .divisor_o       (divisor_o),
    .divisor_valid_o (divisor_valid_o),
    .clk_en_o        (clk_en_o),
    .busy_o          (busy_o)
  );

  always @(negedge clk_i) begin
    for (int c = 0; c < 4; c++) begin
      if (divisor_valid_o[c] === 1'b1) strobe_cnt[c]++;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] chan, input logic [3:0] div);
    req_valid_i   = 1'b1;
    req_chan_i    = chan;
    req_divisor_i = div;
    step();
    req_valid_i = 1'b0;
  endtask

  initial begin
    rst_ni        = 1'b1;
    req_valid_i   = 1'b0;
    req_chan_i    = '0;
    req_divisor_i = '0;
    rsp_ready_i   = 1'b1;
    #1 rst_ni = 1'b0;
    #2;
    chk("rst_divisor", 32'(divisor_o), 32'h1111);
    chk("rst_clk_en", 32'(clk_en_o), 32'hF);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    chk("rst_ready", 32'(req_ready_o), 32'h1);
    #20 rst_ni = 1'b1;
    repeat (10) step();
    chk("idle_divisor", 32'(divisor_o), 32'h1111);
    chk("idle_clk_en", 32'(clk_en_o), 32'hF);
    chk("idle_ready", 32'(req_ready_o), 32'h1);
    chk("idle_strobe", 32'(divisor_valid_o), 32'h0);
    chk("idle_busy", 32'(busy_o), 32'h0);

    // Normal change: chan 2 -> 5, response 35 edges after accept.
    send(3'd2, 4'd5);
    chk("norm_k0_clk_en", 32'(clk_en_o), 32'hB);
    chk("norm_k0_busy", 32'(busy_o), 32'h1);
    chk("norm_k0_ready", 32'(req_ready_o), 32'h0);
    for (int k = 1; k <= 36; k++) begin
      step();
      chk("norm_clk_en", 32'(clk_en_o), (k < 35) ? 32'hB : 32'hF);
      chk("norm_strobe", 32'(divisor_valid_o), (k == 2) ? 32'h4 : 32'h0);
      chk("norm_divisor", 32'(divisor_o), (k >= 2) ? 32'h1511 : 32'h1111);
      chk("norm_rsp_valid", 32'(rsp_valid_o), (k == 35) ? 32'h1 : 32'h0);
      if (k == 35) chk("norm_rsp_error", 32'(rsp_error_o), 32'h0);
    end
    chk("norm_ready_after", 32'(req_ready_o), 32'h1);
    chk("norm_busy_after", 32'(busy_o), 32'h0);
    chk("norm_strobes_ch2", 32'(strobe_cnt[2]), 32'd1);

    // Same divisor again: no-op.
    send(3'd2, 4'd5);
    chk("noop_rsp_valid", 32'(rsp_valid_o), 32'h1);
    chk("noop_rsp_error", 32'(rsp_error_o), 32'h0);
    chk("noop_clk_en", 32'(clk_en_o), 32'hF);
    step();
    chk("noop_done", 32'(rsp_valid_o), 32'h0);
    chk("noop_ready", 32'(req_ready_o), 32'h1);
    chk("noop_strobes_ch2", 32'(strobe_cnt[2]), 32'd1);

    // Zero divisor and out-of-range channel.
    send(3'd1, 4'd0);
    chk("div0_rsp_valid", 32'(rsp_valid_o), 32'h1);
    chk("div0_rsp_error", 32'(rsp_error_o), 32'h1);
    chk("div0_clk_en", 32'(clk_en_o), 32'hF);
    step();
    chk("div0_divisor", 32'(divisor_o), 32'h1511);
    send(3'd7, 4'd3);
    chk("chan7_rsp_valid", 32'(rsp_valid_o), 32'h1);
    chk("chan7_rsp_error", 32'(rsp_error_o), 32'h1);
    step();
    chk("chan7_divisor", 32'(divisor_o), 32'h1511);
    chk("chan7_clk_en", 32'(clk_en_o), 32'hF);

    // Response back-pressure with the request held valid.
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_chan_i = 3'd7;
    req_divisor_i = 4'd4;
    step();
    for (int k = 0; k < 20; k++) begin
      chk("hold_rsp_valid", 32'(rsp_valid_o), 32'h1);
      chk("hold_rsp_error", 32'(rsp_error_o), 32'h1);
      chk("hold_ready", 32'(req_ready_o), 32'h0);
      step();
    end
    rsp_ready_i = 1'b1;
    step();
    chk("rel_rsp_valid", 32'(rsp_valid_o), 32'h0);
    chk("rel_ready", 32'(req_ready_o), 32'h1);
    step();
    chk("rel_reaccept_valid", 32'(rsp_valid_o), 32'h1);
    chk("rel_reaccept_ready", 32'(req_ready_o), 32'h0);
    req_valid_i = 1'b0;
    step();
    chk("rel_idle", 32'(req_ready_o), 32'h1);

    // Reset during SETTLE on chan 1 -> 9.
    send(3'd1, 4'd9);
    repeat (5) step();
    chk("mid_clk_en", 32'(clk_en_o), 32'hD);
    chk("mid_divisor", 32'(divisor_o), 32'h1591);
    #3 rst_ni = 1'b0;
    #1;
    chk("arst_clk_en", 32'(clk_en_o), 32'hF);
    chk("arst_divisor", 32'(divisor_o), 32'h1111);
    chk("arst_busy", 32'(busy_o), 32'h0);
    #12 rst_ni = 1'b1;
    step();
    chk("post_rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    chk("post_rst_ready", 32'(req_ready_o), 32'h1);
    repeat (40) step();
    chk("post_rst_quiet_rsp", 32'(rsp_valid_o), 32'h0);
    chk("post_rst_quiet_clk_en", 32'(clk_en_o), 32'hF);
    chk("strobes_ch0", 32'(strobe_cnt[0]), 32'd0);
    chk("strobes_ch1", 32'(strobe_cnt[1]), 32'd1);
    chk("strobes_ch3", 32'(strobe_cnt[3]), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/hemaia_clk_div_sequencer.md
# hemaia_clk_div_sequencer

Sequences safe divisor changes for a bank of `NumChannels` `hemaia_clock_divider` instances in the HeMAiA clock/reset controller. It accepts one reconfiguration request at a time over a valid/ready port. For each accepted request it gates the target channel's output clock, issues the one-cycle divisor update, and waits for the divider to settle. It then ungates the clock and returns a response. It also holds the shadow copy of every channel's current divisor.

## Interface
- `NumChannels`, 4: number of divider channels driven; ≥1.
- `MaxDivisionWidth`, 4: divisor width; must equal the divider's parameter.
- `DefaultDivision`, 1: reset divisor of every channel; must equal the divider's reset divisor.
- `GateCycles`, 2: cycles spent in GATE before loading; ≥1.
- `SettleCycles`, 32: cycles spent in SETTLE after loading; ≥ 2·(2^MaxDivisionWidth − 1).
- `ChanW`, derived: max(1, $clog2(NumChannels)).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  reconfiguration request valid.
- `req_ready_o`  out  1  request accepted when valid && ready.
- `req_chan_i`  in  ChanW  target channel index.
- `req_divisor_i`  in  MaxDivisionWidth  requested divisor.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumed.
- `rsp_error_o`  out  1  response flag: request rejected; valid with `rsp_valid_o`.
- `divisor_o`  out  NumChannels×MaxDivisionWidth  per-channel divisor, wired to the divider's `divisor_i`.
- `divisor_valid_o`  out  NumChannels  one-cycle load strobe per channel.
- `clk_en_o`  out  NumChannels  per-channel clock-gate enable; 1 = clock passes.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- **Reset values:**
  - `divisor_o[*]` = DefaultDivision, `clk_en_o[*]` = 1.
  - `divisor_valid_o` = 0, `rsp_valid_o` = 0, `rsp_error_o` = 0, `busy_o` = 0.
  - FSM state = IDLE, so `req_ready_o` = 1.
- **FSM states:** IDLE, GATE, LOAD, SETTLE, RESP.
- **IDLE:**
  - `req_ready_o` = 1 (combinational from state only).
  - On accept, the sequencer latches the channel and divisor, then picks one branch:
    - Error: if `req_chan_i` ≥ NumChannels or `req_divisor_i` = 0, go to RESP with error = 1; no output changes.
    - No-op: else if `req_divisor_i` equals `divisor_o[chan]`, go to RESP with error = 0; no gating.
    - Normal: else go to GATE.
- **GATE:**
  - `clk_en_o[chan]` = 0, registered from the accept edge onward.
  - Stay GateCycles cycles, then go to LOAD.
- **LOAD:**
  - Exactly one cycle.
  - `divisor_o[chan]` takes the new value and `divisor_valid_o[chan]` = 1 in the same cycle.
  - Next state is SETTLE.
- **SETTLE:**
  - Stay SettleCycles cycles; `clk_en_o[chan]` stays 0.
  - On exit, `clk_en_o[chan]` returns to 1 and the FSM goes to RESP.
- **RESP:**
  - `rsp_valid_o` = 1 and `rsp_error_o` stays stable until `rsp_ready_i` is sampled high.
  - Then go to IDLE.
  - No new request is accepted before that.
- Only the addressed channel's outputs ever change; the other channels are never disturbed.
- Wait timer:
  - One shared counter of width $clog2(max(GateCycles, SettleCycles) + 1).
  - It is cleared on every state entry.

## Timing
- Accept at edge E0.
- `clk_en_o[chan]` falls after E0.
- `divisor_valid_o` is high in the cycle after E0 + GateCycles.
- `rsp_valid_o` rises after E0 + GateCycles + 1 + SettleCycles; with defaults that is 35 cycles.
- `clk_en_o[chan]` rises at the same edge as `rsp_valid_o`.
- Error and no-op requests: `rsp_valid_o` rises after E0 + 1.
- `rsp_ready_i` already high when RESP is entered: RESP lasts one cycle and `req_ready_o` is 1 on the next cycle.
- `req_valid_i` held high through RESP: it is not accepted until IDLE, so back-to-back requests cost one idle cycle.
- Reset asserted mid-sequence:
  - All outputs return to reset values asynchronously, including `clk_en_o` = 1 and `divisor_o` = default.
  - Any in-flight response is discarded.
  - The dividers reset concurrently, so shadow and actual divisor stay consistent.
- All outputs are driven from flops, except `req_ready_o` and `busy_o`, which are decoded from state.

## Structure
- Package `hemaia_clk_div_seq_pkg` holds:
  - `clk_div_seq_state_e` (IDLE, GATE, LOAD, SETTLE, RESP).
  - `clk_div_req_t` (chan, divisor).
  - Helper function `seq_timer_width`.
- Sub-module `hemaia_clk_div_seq_timer`: loadable down-counter with `start_i`, `load_i`, `done_o`; `done_o` is registered.
- Flat per-channel register arrays live in the top.

## Test plan
- Reset, then idle 10 cycles → `divisor_o` = {1,1,1,1}, `clk_en_o` = 4'b1111, `req_ready_o` = 1, no strobes.
- Request chan=2, div=5, `rsp_ready_i` = 1 → `clk_en_o[2]` low for 35 cycles; one strobe on `divisor_valid_o[2]` with `divisor_o[2]` = 5; response error = 0 at cycle 35; other channels untouched.
- Request chan=2, div=5 again → no-op: response at cycle 1, error = 0, no gating and no strobe.
- Request div=0, and separately chan=7 with NumChannels=4 → error = 1 at cycle 1, nothing changed.
- Hold `rsp_ready_i` = 0 for 20 cycles in RESP with `req_valid_i` held high → `rsp_valid_o` and `rsp_error_o` stable, `req_ready_o` = 0; next request accepted one cycle after release.
- Assert `rst_ni` in SETTLE for chan=1 with div=9 → `clk_en_o[1]` = 1 and `divisor_o[1]` = 1 immediately; `rsp_valid_o` = 0 after release.
